// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage.
//   mem_state_t : handshake FSM states (IDLE, WAIT)
//   REG_ADDR_W  : register-file address width
//   DATA_W      : datapath width
//   wb_bundle_t : one writeback entry {valid, reg_write, addr, data}
package mem_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// Data-memory req/ack handshake for the memory stage.
// Holds the IDLE/WAIT FSM, the request latches and (with MEM_TIMEOUT_EN)
// the timeout counter. It produces a combinational completion bundle that
// the enclosing stage registers as its writeback entry.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_i, mem_read,     execute-stage request and control
//   mem_write, mem_to_reg,
//   reg_write
//   alu_in, rt_val_in,     address/ALU result, store data, destination
//   reg_dst_addr
//   dmem_*                 data-memory interface
//   stall                  access in flight (including its ack cycle)
//   idle                   FSM is in IDLE
//   timeout                access abandoned this cycle (MEM_TIMEOUT_EN)
//   result                 completion bundle, result.valid on ack or timeout
// Optional macro: MEM_TIMEOUT_EN enables the WAIT timeout counter.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  input  logic [DATA_W-1:0]     alu_in,
  input  logic [DATA_W-1:0]     rt_val_in,
  input  logic [REG_ADDR_W-1:0] reg_dst_addr,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DMEM_AW-1:0]    dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic                  stall,
  output logic                  idle,
  output logic                  timeout,
  output wb_bundle_t            result
);

  mem_state_t            state;
  logic [DATA_W-1:0]     alu_q;
  logic [DATA_W-1:0]     rt_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic                  m2r_q;
  logic                  rw_q;
  logic                  wr_q;

  logic                  access;
  logic                  in_wait;
  logic                  done;

  // Gating with rst_n keeps the combinational request low while reset is held.
  assign access  = rst_n & (state == IDLE) & valid_i & (mem_read | mem_write);
  assign in_wait = (state == WAIT);
  assign idle    = (state == IDLE);
  assign stall   = access | in_wait;
  assign done    = dmem_ack & (access | in_wait);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout = in_wait & ~dmem_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (access) begin
      wait_cnt <= '0;
    end else if (in_wait && !dmem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // Request is driven straight from the inputs in the issue cycle and from
  // the latches afterwards, so it stays stable while upstream may change.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (access) begin
      dmem_req   = 1'b1;
      dmem_we    = mem_write;
      dmem_addr  = alu_in[DMEM_AW-1:0];
      dmem_wdata = rt_val_in;
    end else if (in_wait) begin
      dmem_req   = 1'b1;
      dmem_we    = wr_q;
      dmem_addr  = alu_q[DMEM_AW-1:0];
      dmem_wdata = rt_q;
    end
  end

  // Completion bundle: zero-wait completions use the live inputs, since the
  // latches only load at the end of the issue cycle.
  always_comb begin
    logic [DATA_W-1:0]     src_alu;
    logic [REG_ADDR_W-1:0] src_dst;
    logic                  src_m2r;
    logic                  src_rw;
    logic                  src_wr;
    src_alu = access ? alu_in       : alu_q;
    src_dst = access ? reg_dst_addr : dst_q;
    src_m2r = access ? mem_to_reg   : m2r_q;
    src_rw  = access ? reg_write    : rw_q;
    src_wr  = access ? mem_write    : wr_q;
    result           = '0;
    result.valid     = done | timeout;
    // Stores (including read+write) never write the register file.
    result.reg_write = done & src_rw & ~src_wr;
    result.addr      = src_dst;
    result.data      = (done & src_m2r) ? dmem_rdata : src_alu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_q <= '0;
      rt_q  <= '0;
      dst_q <= '0;
      m2r_q <= 1'b0;
      rw_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            alu_q <= alu_in;
            rt_q  <= rt_val_in;
            dst_q <= reg_dst_addr;
            m2r_q <= mem_to_reg & mem_read;
            rw_q  <= reg_write;
            wr_q  <= mem_write;
            if (!dmem_ack) state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack || timeout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage.
// Consumes execute-stage results, performs loads/stores through the
// dmem_handshake sub-module, resolves conditional branches and drives a
// registered writeback entry to the register file.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_i .. reg_dst_addr    execute-stage result and control
//   dmem_req/we/addr/wdata     data-memory request
//   dmem_rdata, dmem_ack       data-memory response
//   stall_o                    freeze upstream while an access is open
//   pc_src, pc_branch_o        registered branch decision and target
//   wb_valid, wb_reg_write,    registered writeback entry
//   wb_addr, wb_data
//   mem_err                    sticky access timeout flag
// Optional macro: MEM_TIMEOUT_EN enables the WAIT timeout and mem_err.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     pc_branch,
  input  logic [DATA_W-1:0]     alu_in,
  input  logic [DATA_W-1:0]     rt_val_in,
  input  logic [REG_ADDR_W-1:0] reg_dst_addr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DMEM_AW-1:0]    dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall_o,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     pc_branch_o,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  mem_err
);

  logic       idle;
  logic       timeout;
  logic       pass;
  wb_bundle_t result;
  wb_bundle_t wb_q;

  dmem_handshake #(
    .DMEM_AW        (DMEM_AW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_hs (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_in       (alu_in),
    .rt_val_in    (rt_val_in),
    .reg_dst_addr (reg_dst_addr),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .stall        (stall_o),
    .idle         (idle),
    .timeout      (timeout),
    .result       (result)
  );

  // Non-memory instructions complete directly from IDLE.
  assign pass = idle & valid_i & ~mem_read & ~mem_write;

  // Writeback register: valid/reg_write pulse, addr/data hold between entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
      if (pass) begin
        wb_q.valid     <= 1'b1;
        wb_q.reg_write <= reg_write;
        wb_q.addr      <= reg_dst_addr;
        wb_q.data      <= alu_in;
      end else if (result.valid) begin
        wb_q <= result;
      end
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_addr      = wb_q.addr;
  assign wb_data      = wb_q.data;

  // Branch resolution happens only in IDLE; pc_src is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_src      <= 1'b0;
      pc_branch_o <= '0;
    end else begin
      pc_src <= idle & valid_i & branch & zero;
      if (idle && valid_i && branch) pc_branch_o <= pc_branch;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, mem_read, mem_write, branch, reg_write, mem_to_reg, zero;
  logic [31:0] pc_branch, alu_in, rt_val_in, dmem_rdata;
  logic [4:0]  reg_dst_addr;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall_o, pc_src, wb_valid, wb_reg_write, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_o, wb_data;
  logic [4:0]  wb_addr;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_AW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .zero(zero), .pc_branch(pc_branch),
    .alu_in(alu_in), .rt_val_in(rt_val_in), .reg_dst_addr(reg_dst_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_o(stall_o), .pc_src(pc_src), .pc_branch_o(pc_branch_o),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    valid_i = 0; mem_read = 0; mem_write = 0; branch = 0; reg_write = 0;
    mem_to_reg = 0; zero = 0; pc_branch = 0; alu_in = 0; rt_val_in = 0;
    reg_dst_addr = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    got = {dmem_req, stall_o, wb_valid, pc_src};
    total++;
    if (got !== 4'b0) $display("FAIL reset_ctrl got=%b want=0000", got);
    else pass_cnt++;
    total++;
    if (wb_data !== 32'h0 || wb_addr !== 5'h0 || mem_err !== 1'b0)
      $display("FAIL reset_data got data=%h addr=%h err=%b want 0", wb_data, wb_addr, mem_err);
    else pass_cnt++;
  endtask

  task automatic test_rtype;
    valid_i = 1; reg_write = 1; alu_in = 32'h2A; reg_dst_addr = 5'd5;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL rtype_stall got=%b want=0", stall_o);
    else pass_cnt++;
    tick;
    clear_inputs;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'h2A)
      $display("FAIL rtype_wb got v=%b rw=%b a=%0d d=%h want v=1 rw=1 a=5 d=0000002a",
               wb_valid, wb_reg_write, wb_addr, wb_data);
    else pass_cnt++;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL rtype_stall2 got=%b want=0", stall_o);
    else pass_cnt++;
  endtask

  task automatic test_load_wait;
    int stall_cycles;
    stall_cycles = 0;
    valid_i = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1;
    alu_in = 32'h10; reg_dst_addr = 5'd7;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
      #1;
      if (stall_o === 1'b1) stall_cycles++;
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h10)
        $display("FAIL load_req_c%0d got req=%b we=%b addr=%h want 1 0 00000010",
                 c, dmem_req, dmem_we, dmem_addr);
      else pass_cnt++;
      if (c == 2) begin
        total++;
        if (wb_valid !== 1'b0) $display("FAIL load_early_wb got=%b want=0", wb_valid);
        else pass_cnt++;
      end
      tick;
      // Upstream changes are ignored once the request is latched.
      valid_i = 0; mem_read = 0; alu_in = 32'h99; reg_dst_addr = 5'd1;
    end
    dmem_ack = 0; dmem_rdata = 0;
    #1;
    total++;
    if (stall_cycles != 4 || stall_o !== 1'b0)
      $display("FAIL load_stall got cycles=%0d now=%b want 4 0", stall_cycles, stall_o);
    else pass_cnt++;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'hDEADBEEF)
      $display("FAIL load_wb got v=%b rw=%b a=%0d d=%h want 1 1 7 deadbeef",
               wb_valid, wb_reg_write, wb_addr, wb_data);
    else pass_cnt++;
    clear_inputs;
    tick;
  endtask

  task automatic test_zero_wait_store;
    valid_i = 1; mem_write = 1; reg_write = 1; alu_in = 32'h20; rt_val_in = 32'h55;
    reg_dst_addr = 5'd9; dmem_ack = 1;
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h55 || stall_o !== 1'b1)
      $display("FAIL store_req got req=%b we=%b wd=%h st=%b want 1 1 00000055 1",
               dmem_req, dmem_we, dmem_wdata, stall_o);
    else pass_cnt++;
    tick;
    clear_inputs;
    #1;
    total++;
    if (stall_o !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL store_stall got st=%b req=%b want 0 0", stall_o, dmem_req);
    else pass_cnt++;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h20)
      $display("FAIL store_wb got v=%b rw=%b d=%h want 1 0 00000020", wb_valid, wb_reg_write, wb_data);
    else pass_cnt++;
    tick;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h20 || wb_addr !== 5'd9)
      $display("FAIL idle_hold got v=%b d=%h a=%0d want 0 00000020 9", wb_valid, wb_data, wb_addr);
    else pass_cnt++;
  endtask

  task automatic test_read_write_both;
    valid_i = 1; mem_read = 1; mem_write = 1; reg_write = 1; alu_in = 32'h30;
    reg_dst_addr = 5'd3; dmem_ack = 1;
    #1;
    total++;
    if (dmem_we !== 1'b1) $display("FAIL rw_both_we got=%b want=1", dmem_we);
    else pass_cnt++;
    tick;
    clear_inputs;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
      $display("FAIL rw_both_wb got v=%b rw=%b want 1 0", wb_valid, wb_reg_write);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_branch;
    valid_i = 1; branch = 1; zero = 1; pc_branch = 32'h40;
    tick;
    clear_inputs;
    total++;
    if (pc_src !== 1'b1 || pc_branch_o !== 32'h40)
      $display("FAIL branch_taken got src=%b tgt=%h want 1 00000040", pc_src, pc_branch_o);
    else pass_cnt++;
    tick;
    total++;
    if (pc_src !== 1'b0) $display("FAIL branch_pulse got=%b want=0", pc_src);
    else pass_cnt++;
    valid_i = 1; branch = 1; zero = 0; pc_branch = 32'h80;
    tick;
    clear_inputs;
    total++;
    if (pc_src !== 1'b0) $display("FAIL branch_not_taken got=%b want=0", pc_src);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    valid_i = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu_in = 32'h44; reg_dst_addr = 5'd2;
    tick;
    valid_i = 0; mem_read = 0;
    tick;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_o !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL rst_wait got req=%b st=%b v=%b want 0 0 0", dmem_req, stall_o, wb_valid);
    else pass_cnt++;
    tick;
    rst_n = 1;
    clear_inputs;
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL stray_ack_req got req=%b st=%b want 0 0", dmem_req, stall_o);
    else pass_cnt++;
    tick;
    dmem_ack = 0;
    total++;
    if (wb_valid !== 1'b0) $display("FAIL stray_ack_wb got=%b want=0", wb_valid);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    valid_i = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu_in = 32'h50; reg_dst_addr = 5'd4;
    tick;
    clear_inputs;
`ifdef MEM_TIMEOUT_EN
    for (int w = 1; w <= 4; w++) begin
      total++;
      if (dmem_req !== 1'b1) $display("FAIL to_req_w%0d got=%b want=1", w, dmem_req);
      else pass_cnt++;
      tick;
    end
    total++;
    if (dmem_req !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL to_drop got req=%b st=%b want 0 0", dmem_req, stall_o);
    else pass_cnt++;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || mem_err !== 1'b1)
      $display("FAIL to_wb got v=%b rw=%b err=%b want 1 0 1", wb_valid, wb_reg_write, mem_err);
    else pass_cnt++;
    valid_i = 1; reg_write = 1; alu_in = 32'h7; reg_dst_addr = 5'd8;
    tick;
    clear_inputs;
    tick;
    total++;
    if (mem_err !== 1'b1) $display("FAIL to_sticky got=%b want=1", mem_err);
    else pass_cnt++;
`else
    repeat (8) tick;
    total++;
    if (dmem_req !== 1'b1 || stall_o !== 1'b1 || mem_err !== 1'b0)
      $display("FAIL no_timeout got req=%b st=%b err=%b want 1 1 0", dmem_req, stall_o, mem_err);
    else pass_cnt++;
    dmem_ack = 1; dmem_rdata = 32'hCAFE0001;
    tick;
    dmem_ack = 0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE0001 || wb_addr !== 5'd4)
      $display("FAIL long_wait_wb got v=%b d=%h a=%0d want 1 cafe0001 4", wb_valid, wb_data, wb_addr);
    else pass_cnt++;
`endif
  endtask

  initial begin
    rst_n = 0;
    clear_inputs;
    repeat (2) tick;
    test_reset;
    rst_n = 1;
    tick;
    test_rtype;
    test_load_wait;
    test_zero_wait_store;
    test_read_write_both;
    test_branch;
    test_reset_mid_wait;
    test_timeout;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory stage: the downstream consumer of execute-stage results (ALU result, store data, destination register, zero flag, branch target).
- Performs loads and stores through a req/ack data-memory handshake, resolves branches, and drives registered writeback outputs to the register file.
- Asserts stall upstream while a memory access is outstanding.

Parameters:
- DMEM_AW, 32, data-memory address width; dmem_addr = alu_in[DMEM_AW-1:0].
- TIMEOUT_CYCLES, 16, cycles in WAIT before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  execute-stage result valid this cycle
- mem_read  input  1  instruction is a load
- mem_write  input  1  instruction is a store
- branch  input  1  instruction is a conditional branch
- reg_write  input  1  instruction writes the register file
- mem_to_reg  input  1  writeback data is the load result, not the ALU result
- zero  input  1  ALU zero flag
- pc_branch  input  32  branch target
- alu_in  input  32  ALU result, also the memory address
- rt_val_in  input  32  store data
- reg_dst_addr  input  5  destination register
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = store
- dmem_addr  output  DMEM_AW  word address
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  load data, valid with dmem_ack
- dmem_ack  input  1  request complete
- stall_o  output  1  freeze upstream stages
- pc_src  output  1  take branch
- pc_branch_o  output  32  registered branch target
- wb_valid  output  1  writeback entry valid
- wb_reg_write  output  1  register-file write enable
- wb_addr  output  5  register-file write address
- wb_data  output  32  register-file write data
- mem_err  output  1  access timed out (MEM_TIMEOUT_EN only)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal latches cleared. Reset is asynchronous, so asserting rst_n low in WAIT aborts immediately: dmem_req drops and no writeback is produced.
- FSM states: IDLE and WAIT.
- IDLE, valid_i=1 with neither mem_read nor mem_write:
  - Next edge: wb_valid=1, wb_reg_write=reg_write, wb_addr=reg_dst_addr, wb_data=alu_in.
  - Latency is 1 cycle.
- IDLE, valid_i=1 with mem_read or mem_write:
  - Combinationally: dmem_req=1, dmem_we=mem_write, dmem_addr and dmem_wdata driven from the inputs, stall_o=1.
  - Same cycle: alu_in, rt_val_in, reg_dst_addr, mem_to_reg, reg_write and mem_read are latched.
  - Next edge: move to WAIT.
  - If dmem_ack is already 1 in this cycle, the access completes in zero wait: take the completion path directly and stay in IDLE.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are driven from the latches and held stable until ack.
  - stall_o=1 every cycle until the ack cycle, inclusive.
  - On dmem_ack=1: return to IDLE.
  - Next edge after ack: wb_valid=1; wb_data = latched mem_to_reg ? dmem_rdata (sampled in the ack cycle) : latched alu.
  - A store gives wb_reg_write=0.
- Loads and stores: writeback appears the cycle after ack.
- Idle cycles: wb_valid and wb_reg_write are 0 on any cycle without a completion; wb_data and wb_addr hold their last values.
- Branch resolution:
  - Next edge: pc_src = valid_i & branch & zero; pc_branch_o is registered from pc_branch.
  - pc_src is a 1-cycle pulse and is evaluated only in IDLE.
- Both mem_read and mem_write set: treated as a store (dmem_we=1); wb_reg_write is forced to 0.
- Inputs in WAIT: valid_i and data inputs are ignored; upstream holds them under stall_o.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: the request is dropped and the FSM returns to IDLE.
  - The next edge then gives wb_valid=1, wb_reg_write=0, and a sticky mem_err=1, cleared only by reset.
- Undefined: no counter; WAIT lasts indefinitely; mem_err is tied to 0.

Decomposition:
- definitions package: mem_state_t enum {IDLE, WAIT}; constants REG_ADDR_W=5 and DATA_W=32; a packed struct wb_bundle_t {valid, reg_write, addr, data}.
- One natural sub-module: dmem_handshake, holding the FSM, request latches and the optional timeout counter. mem_stage wraps it with branch resolution and the writeback register.

Test Plan:
- R-type pass-through:
  - Stimulus: valid_i=1, reg_write=1, alu_in=0x0000002A, reg_dst_addr=5.
  - Required: next cycle wb_valid=1, wb_addr=5, wb_data=0x2A, stall_o never asserted.
- Load with 3 wait cycles:
  - Stimulus: mem_read, alu_in=0x10; ack asserted on the 4th cycle with rdata=0xDEADBEEF.
  - Required: dmem_addr=0x10 held throughout; stall_o high for 4 cycles; wb_data=0xDEADBEEF one cycle after ack.
- Zero-wait store:
  - Stimulus: mem_write, alu_in=0x20, rt_val_in=0x55; ack in the same cycle.
  - Required: dmem_we=1, dmem_wdata=0x55, stall_o=1 for 1 cycle, wb_reg_write=0.
- Branch:
  - Stimulus: branch=1, zero=1, pc_branch=0x40.
  - Required: pc_src pulses 1 for one cycle with pc_branch_o=0x40. Repeat with zero=0: pc_src stays 0.
- Reset mid-WAIT:
  - Stimulus: rst_n low two cycles after a load request, before ack.
  - Required: dmem_req, stall_o and wb_valid are all 0 immediately; after release, an ack arriving with no request is ignored.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: load request, ack never asserted.
  - Required: dmem_req drops after 4 WAIT cycles; mem_err=1 and remains set; wb_reg_write=0.
